// File: rtl/board_vga_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : board_vga_renderer
//  Purpose  : 640x480@60 VGA renderer for the 12x10 board colour array, with
//             per-frame snapshot. Optional grid overlay: BOARD_GRID_LINES_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module board_vga_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_PX  = 40,
  parameter int X_OFFSET = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:79] colorValues [0:11],
  input  logic        color_valid,
  output logic        frame_sync,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 12;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW         = $clog2(H_TOTAL + 1);
  localparam int VW         = $clog2(V_TOTAL + 1);
  localparam int SW         = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int IW         = 4;

  localparam logic [HW-1:0] c_h_last    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_h_active  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_hs_start  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_hs_end    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] c_col_start = HW'((X_OFFSET == 0) ? (H_TOTAL - 1) : (X_OFFSET - 1));
  localparam logic [HW-1:0] c_board_x0  = HW'(X_OFFSET);
  localparam logic [HW-1:0] c_board_x1  = HW'(X_OFFSET + BOARD_COLS * CELL_PX);
  localparam logic [VW-1:0] c_v_last    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_v_active  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_vs_start  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_vs_end    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] c_board_y1  = VW'(BOARD_ROWS * CELL_PX);
  localparam logic [SW-1:0] c_sub_last  = SW'(CELL_PX - 1);
  localparam logic [IW-1:0] c_cols      = IW'(BOARD_COLS);
  localparam logic [IW-1:0] c_rows      = IW'(BOARD_ROWS);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [SW-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
  logic [IW-1:0] col_idx_q, col_idx_d, row_idx_q, row_idx_d;
  logic          w_h_wrap, w_v_wrap, w_frame_start, w_in_board;

  logic          s1_in_board_q, s1_hsync_q, s1_vsync_q;
  logic [IW-1:0] s1_row_q, s1_col_q;
  logic          s2_hsync_q, s2_vsync_q;
  logic [3:0]    s2_r_q, s2_g_q, s2_b_q;
  logic [3:0]    w_r, w_g, w_b;
  logic [0:79]   w_row_bits;
  logic [7:0]    w_cell;
  logic [0:79]   snap_q [0:BOARD_ROWS-1];
`ifdef BOARD_GRID_LINES_EN
  logic          s1_grid_q;
`endif

  assign w_h_wrap      = (h_cnt_q == c_h_last);
  assign w_v_wrap      = (v_cnt_q == c_v_last);
  assign w_frame_start = (h_cnt_q == '0) && (v_cnt_q == c_v_active);

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (w_h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = w_v_wrap ? '0 : (v_cnt_q + VW'(1));
    end
  end

  // Cell indices saturate at the board size; saturated values mean "off board".
  always_comb begin
    col_sub_d = col_sub_q + SW'(1);
    col_idx_d = col_idx_q;
    if (h_cnt_q == c_col_start) begin
      col_sub_d = '0;
      col_idx_d = '0;
    end else if (col_sub_q == c_sub_last) begin
      col_sub_d = '0;
      if (col_idx_q != c_cols) col_idx_d = col_idx_q + IW'(1);
    end

    row_sub_d = row_sub_q;
    row_idx_d = row_idx_q;
    if (w_h_wrap) begin
      if (w_v_wrap) begin
        row_sub_d = '0;
        row_idx_d = '0;
      end else if (row_sub_q == c_sub_last) begin
        row_sub_d = '0;
        if (row_idx_q != c_rows) row_idx_d = row_idx_q + IW'(1);
      end else begin
        row_sub_d = row_sub_q + SW'(1);
      end
    end
  end

  assign w_in_board = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active) &&
                      (h_cnt_q >= c_board_x0) && (h_cnt_q < c_board_x1) &&
                      (v_cnt_q < c_board_y1) &&
                      (col_idx_q < c_cols) && (row_idx_q < c_rows);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      col_sub_q     <= '0;
      col_idx_q     <= '0;
      row_sub_q     <= '0;
      row_idx_q     <= '0;
      s1_in_board_q <= 1'b0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      s1_hsync_q    <= 1'b1;
      s1_vsync_q    <= 1'b1;
`ifdef BOARD_GRID_LINES_EN
      s1_grid_q     <= 1'b0;
`endif
      s2_hsync_q    <= 1'b1;
      s2_vsync_q    <= 1'b1;
      s2_r_q        <= '0;
      s2_g_q        <= '0;
      s2_b_q        <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      col_sub_q     <= col_sub_d;
      col_idx_q     <= col_idx_d;
      row_sub_q     <= row_sub_d;
      row_idx_q     <= row_idx_d;
      s1_in_board_q <= w_in_board;
      s1_row_q      <= row_idx_q;
      s1_col_q      <= col_idx_q;
      s1_hsync_q    <= !((h_cnt_q >= c_hs_start) && (h_cnt_q <= c_hs_end));
      s1_vsync_q    <= !((v_cnt_q >= c_vs_start) && (v_cnt_q <= c_vs_end));
`ifdef BOARD_GRID_LINES_EN
      s1_grid_q     <= (col_sub_q == '0) || (row_sub_q == '0);
`endif
      s2_hsync_q    <= s1_hsync_q;
      s2_vsync_q    <= s1_vsync_q;
      s2_r_q        <= w_r;
      s2_g_q        <= w_g;
      s2_b_q        <= w_b;
    end
  end

  // Mux-based select keeps the read in range even for saturated indices.
  always_comb begin
    w_row_bits = snap_q[0];
    for (int i = 0; i < BOARD_ROWS; i++) begin
      if (s1_row_q == IW'(i)) w_row_bits = snap_q[i];
    end
    w_cell = 8'h00;
    for (int j = 0; j < BOARD_COLS; j++) begin
      if (s1_col_q == IW'(j)) w_cell = w_row_bits[j*8 +: 8];
    end
    w_r = 4'h0;
    w_g = 4'h0;
    w_b = 4'h0;
    if (s1_in_board_q) begin
      w_r = {w_cell[7:5], w_cell[7]};
      w_g = {w_cell[4:2], w_cell[4]};
      w_b = {w_cell[1:0], w_cell[1:0]};
`ifdef BOARD_GRID_LINES_EN
      if (s1_grid_q) begin
        w_r = 4'h4;
        w_g = 4'h9;
        w_b = 4'h5;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BOARD_ROWS; i++) snap_q[i] <= '0;
    end else if (w_frame_start && color_valid) begin
      for (int i = 0; i < BOARD_ROWS; i++) snap_q[i] <= colorValues[i];
    end
  end

  assign frame_sync = w_frame_start;
  assign vga_hsync  = s2_hsync_q;
  assign vga_vsync  = s2_vsync_q;
  assign vga_r      = s2_r_q;
  assign vga_g      = s2_g_q;
  assign vga_b      = s2_b_q;

endmodule
`default_nettype wire
